// File: rtl/uart_fifo_pkg.sv
// -----------------------------------------------------------------------------
// uart_fifo_pkg
// Shared definitions for the UART transmit FIFO slice:
//   - status bit positions reported by the attached FIFO
//   - drain FSM state encoding used by uart_tx_fifo_sequencer
//   - default FIFO address width
// -----------------------------------------------------------------------------
package uart_fifo_pkg;

    // Default FIFO address width; usable depth is (1 << width) - 1.
    localparam int UART_FIFO_ADDR_WIDTH = 4;

    // Bit positions inside the FIFO status word.
    localparam int FIFO_STAT_EMPTY  = 0;
    localparam int FIFO_STAT_FULL   = 1;
    localparam int FIFO_STAT_AFULL  = 2;
    localparam int FIFO_STAT_AEMPTY = 3;
    localparam int FIFO_STAT_WIDTH  = 4;

    // Drain FSM states.
    //   S_IDLE  : waiting for data, enable and an idle transmitter
    //   S_READ  : FIFO read strobe is high for this single cycle
    //   S_LOAD  : Tx_Start pulse, Tx_Data carries the fetched byte
    //   S_HOLD  : gives the transmitter one cycle to raise Tx_Busy
    //   S_DRAIN : waits for the transmitter to finish the frame
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_LOAD  = 3'd2,
        S_HOLD  = 3'd3,
        S_DRAIN = 3'd4
    } drain_state_e;

endpackage : uart_fifo_pkg

// File: rtl/uart_tx_fifo_sequencer_rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Two-requester round-robin grant logic, purely combinational.
// The last-grant history register lives in the parent.
//
// Ports:
//   valid0, valid1 : request lines from source 0 / source 1
//   last_grant     : index of the source granted most recently (0 or 1)
//   block          : when high no grant is issued (destination full)
//   grant0, grant1 : one-hot (or zero) grant outputs
// -----------------------------------------------------------------------------
module rr_arbiter2
    import uart_fifo_pkg::*;
(
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    input  logic block,
    output logic grant0,
    output logic grant1
);

    // Grant selection: single requester wins outright, contention goes to
    // the source that was not served last.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (block) begin
            grant0 = 1'b0;
            grant1 = 1'b0;
        end else if (valid0 && valid1) begin
            grant0 = last_grant;
            grant1 = ~last_grant;
        end else begin
            grant0 = valid0;
            grant1 = valid1;
        end
    end

endmodule : rr_arbiter2

// File: rtl/uart_tx_fifo_sequencer.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_sequencer
// Controller around the 8-bit UART transmit FIFO. Two byte producers are
// merged into the FIFO write port by round-robin arbitration, and the FIFO is
// drained into the UART shifter through a start/busy handshake. An internal
// occupancy count (Level) drives all accept/read decisions so the FIFO's own
// registered status flags are never relied upon.
//
// Ports:
//   Clk                     clock, all state updates on the rising edge
//   Reset                   synchronous, active-low
//   Req0_Valid/Data/Ready   byte source 0 (Ready is combinational)
//   Req1_Valid/Data/Ready   byte source 1 (Ready is combinational)
//   Fifo_Write, Fifo_Wdata  registered FIFO write strobe and data
//   Fifo_Read               registered FIFO read strobe
//   Fifo_Rdata              FIFO read data, valid after the read negedge
//   Tx_Enable               0 pauses draining (sampled only in IDLE)
//   Tx_Start                one-cycle start pulse to the transmitter
//   Tx_Data                 byte for the transmitter, held until next load
//   Tx_Busy                 transmitter is shifting a frame
//   Level                   internal occupancy count, 0..DEPTH
// -----------------------------------------------------------------------------
module uart_tx_fifo_sequencer
    import uart_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = UART_FIFO_ADDR_WIDTH,
    parameter int DEPTH      = (1 << ADDR_WIDTH) - 1
)
(
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Req0_Valid,
    input  logic [7:0]            Req0_Data,
    output logic                  Req0_Ready,
    input  logic                  Req1_Valid,
    input  logic [7:0]            Req1_Data,
    output logic                  Req1_Ready,
    output logic                  Fifo_Write,
    output logic [7:0]            Fifo_Wdata,
    output logic                  Fifo_Read,
    input  logic [7:0]            Fifo_Rdata,
    input  logic                  Tx_Enable,
    output logic                  Tx_Start,
    output logic [7:0]            Tx_Data,
    input  logic                  Tx_Busy,
    output logic [ADDR_WIDTH-1:0] Level
);

    localparam logic [ADDR_WIDTH-1:0] LEVEL_FULL = ADDR_WIDTH'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LEVEL_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] LEVEL_ZERO = ADDR_WIDTH'(0);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    drain_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] level_q, level_d;
    logic                  last_grant_q, last_grant_d;
    logic                  fifo_write_q, fifo_write_d;
    logic [7:0]            fifo_wdata_q, fifo_wdata_d;
    logic                  fifo_read_q, fifo_read_d;
    logic                  tx_start_q, tx_start_d;
    logic [7:0]            tx_data_q, tx_data_d;

    // Combinational decisions
    logic full;
    logic grant0;
    logic grant1;
    logic accept0;
    logic accept1;
    logic accept;
    logic rd_go;

    // Acceptance is blocked purely on the internal count; a read decided in
    // the same cycle does not free a slot until the next cycle.
    assign full = (level_q == LEVEL_FULL);

    rr_arbiter2 u_arb (
        .valid0     (Req0_Valid),
        .valid1     (Req1_Valid),
        .last_grant (last_grant_q),
        .block      (full),
        .grant0     (grant0),
        .grant1     (grant1)
    );

    assign accept0 = Req0_Valid & grant0;
    assign accept1 = Req1_Valid & grant1;
    assign accept  = accept0 | accept1;

    // Read decision only from IDLE. Level counts a byte from the edge it is
    // accepted, so the earliest read follows the FIFO write by one cycle.
    assign rd_go = (state_q == S_IDLE) & Tx_Enable & (level_q != LEVEL_ZERO) & ~Tx_Busy;

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------

    // Write strobe/data, arbitration history and occupancy next values.
    always_comb begin
        last_grant_d = last_grant_q;
        fifo_write_d = 1'b0;
        fifo_wdata_d = fifo_wdata_q;
        level_d      = level_q;

        if (accept1) begin
            last_grant_d = 1'b1;
            fifo_write_d = 1'b1;
            fifo_wdata_d = Req1_Data;
        end else if (accept0) begin
            last_grant_d = 1'b0;
            fifo_write_d = 1'b1;
            fifo_wdata_d = Req0_Data;
        end else begin
            last_grant_d = last_grant_q;
            fifo_write_d = 1'b0;
            fifo_wdata_d = fifo_wdata_q;
        end

        // Accept and read in the same cycle cancel out.
        if (accept && !rd_go) begin
            level_d = level_q + LEVEL_ONE;
        end else if (!accept && rd_go) begin
            level_d = level_q - LEVEL_ONE;
        end else begin
            level_d = level_q;
        end
    end

    // ------------------------------------------------------------------
    // Drain FSM
    // ------------------------------------------------------------------

    // Drain FSM state register.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Drain FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (rd_go) begin
                    state_d = S_READ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ:  state_d = S_LOAD;
            S_LOAD:  state_d = S_HOLD;
            // HOLD gives the transmitter a cycle to assert Tx_Busy before
            // DRAIN starts looking at it.
            S_HOLD:  state_d = S_DRAIN;
            S_DRAIN: begin
                if (!Tx_Busy) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Drain FSM output logic: next values of the registered read/start/data.
    // Fifo_Read is registered from the IDLE decision so it is high during
    // READ; Fifo_Rdata is valid by the end of READ and captured so that
    // Tx_Data and Tx_Start appear together during LOAD.
    always_comb begin
        fifo_read_d = 1'b0;
        tx_start_d  = 1'b0;
        tx_data_d   = tx_data_q;
        case (state_q)
            S_IDLE: begin
                fifo_read_d = rd_go;
                tx_start_d  = 1'b0;
                tx_data_d   = tx_data_q;
            end
            S_READ: begin
                fifo_read_d = 1'b0;
                tx_start_d  = 1'b1;
                tx_data_d   = Fifo_Rdata;
            end
            default: begin
                fifo_read_d = 1'b0;
                tx_start_d  = 1'b0;
                tx_data_d   = tx_data_q;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------

    // Registered outputs, occupancy count and last-grant history.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            level_q      <= LEVEL_ZERO;
            last_grant_q <= 1'b1;
            fifo_write_q <= 1'b0;
            fifo_wdata_q <= 8'h00;
            fifo_read_q  <= 1'b0;
            tx_start_q   <= 1'b0;
            tx_data_q    <= 8'h00;
        end else begin
            level_q      <= level_d;
            last_grant_q <= last_grant_d;
            fifo_write_q <= fifo_write_d;
            fifo_wdata_q <= fifo_wdata_d;
            fifo_read_q  <= fifo_read_d;
            tx_start_q   <= tx_start_d;
            tx_data_q    <= tx_data_d;
        end
    end

    assign Req0_Ready = grant0;
    assign Req1_Ready = grant1;
    assign Fifo_Write = fifo_write_q;
    assign Fifo_Wdata = fifo_wdata_q;
    assign Fifo_Read  = fifo_read_q;
    assign Tx_Start   = tx_start_q;
    assign Tx_Data    = tx_data_q;
    assign Level      = level_q;

endmodule : uart_tx_fifo_sequencer

// File: tb/tb_uart_tx_fifo_sequencer.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo_sequencer
// Directed bench: a cycle table for arbitration/write behaviour, then
// hand-written sequences for latency, fill/drain, full boundary, balanced
// accept/read and mid-frame reset. A behavioural FIFO and a transmitter busy
// model are attached to the DUT.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo_sequencer;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Req0_Valid;
    logic [7:0] Req0_Data;
    logic       Req0_Ready;
    logic       Req1_Valid;
    logic [7:0] Req1_Data;
    logic       Req1_Ready;
    logic       Fifo_Write;
    logic [7:0] Fifo_Wdata;
    logic       Fifo_Read;
    logic [7:0] Fifo_Rdata = 8'h00;
    logic       Tx_Enable;
    logic       Tx_Start;
    logic [7:0] Tx_Data;
    logic       Tx_Busy = 1'b0;
    logic [3:0] Level;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    uart_tx_fifo_sequencer dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Req0_Valid (Req0_Valid),
        .Req0_Data  (Req0_Data),
        .Req0_Ready (Req0_Ready),
        .Req1_Valid (Req1_Valid),
        .Req1_Data  (Req1_Data),
        .Req1_Ready (Req1_Ready),
        .Fifo_Write (Fifo_Write),
        .Fifo_Wdata (Fifo_Wdata),
        .Fifo_Read  (Fifo_Read),
        .Fifo_Rdata (Fifo_Rdata),
        .Tx_Enable  (Tx_Enable),
        .Tx_Start   (Tx_Start),
        .Tx_Data    (Tx_Data),
        .Tx_Busy    (Tx_Busy),
        .Level      (Level)
    );

    // FIFO and transmitter models, acting mid low-phase.
    logic [7:0] fifo_m[$];
    logic [7:0] tx_log[$];
    int         wr_cnt = 0;
    int         rd_cnt = 0;
    int         busy_viol = 0;
    int         busy_cnt = 0;

    always @(negedge Clk) begin
        #2;
        if (!Reset) begin
            fifo_m.delete();
            busy_cnt = 0;
            Tx_Busy  = 1'b0;
        end else begin
            if (Fifo_Write) begin
                fifo_m.push_back(Fifo_Wdata);
                wr_cnt++;
            end
            if (Fifo_Read) begin
                rd_cnt++;
                if (fifo_m.size() > 0) Fifo_Rdata = fifo_m.pop_front();
            end
            if (Tx_Start) begin
                if (Tx_Busy) busy_viol++;
                tx_log.push_back(Tx_Data);
                busy_cnt = 10;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
            end
            Tx_Busy = (busy_cnt != 0);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(negedge Clk);
    endtask

    // Leaves the caller at a negedge with the DUT just reset, Reset released.
    task automatic do_reset();
        cyc();
        Reset      = 1'b0;
        Req0_Valid = 1'b0;
        Req1_Valid = 1'b0;
        Req0_Data  = 8'h00;
        Req1_Data  = 8'h00;
        Tx_Enable  = 1'b0;
        cyc();
        Reset = 1'b1;
    endtask

    task automatic fill0(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            Req0_Valid = 1'b1;
            Req0_Data  = base + 8'(i);
            cyc();
        end
        Req0_Valid = 1'b0;
        cyc();
    endtask

    typedef struct {
        logic       v0;
        logic [7:0] d0;
        logic       v1;
        logic [7:0] d1;
        logic       r0;
        logic       r1;
        logic       fw;
        logic [7:0] wd;
        logic [3:0] lvl;
    } vec_t;

    vec_t       vecs[7];
    logic [7:0] exp_q[$];
    int         wbase;
    int         rbase;
    int         lbase;

    initial begin
        //             v0  d0     v1  d1     r0  r1  fw  wd     lvl
        vecs[0] = '{1'b1, 8'hA1, 1'b1, 8'hB1, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0};
        vecs[1] = '{1'b1, 8'hA2, 1'b1, 8'hB2, 1'b0, 1'b1, 1'b1, 8'hA1, 4'd1};
        vecs[2] = '{1'b0, 8'h00, 1'b1, 8'hB3, 1'b0, 1'b1, 1'b1, 8'hB2, 4'd2};
        vecs[3] = '{1'b1, 8'hA3, 1'b1, 8'hB4, 1'b1, 1'b0, 1'b1, 8'hB3, 4'd3};
        vecs[4] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA3, 4'd4};
        vecs[5] = '{1'b1, 8'hA4, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hA3, 4'd4};
        vecs[6] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA4, 4'd5};

        Reset = 1'b0;
        Req0_Valid = 1'b0; Req1_Valid = 1'b0;
        Req0_Data = 8'h00; Req1_Data = 8'h00;
        Tx_Enable = 1'b0;
        repeat (2) cyc();

        // ---- table: arbitration and write path, draining paused ----
        do_reset();
        for (int i = 0; i < 7; i++) begin
            Req0_Valid = vecs[i].v0; Req0_Data = vecs[i].d0;
            Req1_Valid = vecs[i].v1; Req1_Data = vecs[i].d1;
            #1;
            check($sformatf("tbl%0d_ready0", i), Req0_Ready, vecs[i].r0);
            check($sformatf("tbl%0d_ready1", i), Req1_Ready, vecs[i].r1);
            check($sformatf("tbl%0d_fwrite", i), Fifo_Write, vecs[i].fw);
            check($sformatf("tbl%0d_wdata", i), Fifo_Wdata, vecs[i].wd);
            check($sformatf("tbl%0d_level", i), Level, vecs[i].lvl);
            check($sformatf("tbl%0d_fread", i), Fifo_Read, 1'b0);
            cyc();
        end

        // ---- single byte latency ----
        do_reset();
        #1;
        check("rst_fwrite", Fifo_Write, 1'b0);
        check("rst_wdata", Fifo_Wdata, 8'h00);
        check("rst_fread", Fifo_Read, 1'b0);
        check("rst_txstart", Tx_Start, 1'b0);
        check("rst_txdata", Tx_Data, 8'h00);
        check("rst_level", Level, 4'd0);
        rbase = rd_cnt;
        Tx_Enable = 1'b1;
        Req0_Valid = 1'b1; Req0_Data = 8'h41;
        #1 check("lat_ready0", Req0_Ready, 1'b1);
        cyc(); Req0_Valid = 1'b0;
        #1;
        check("lat_fwrite", Fifo_Write, 1'b1);
        check("lat_wdata", Fifo_Wdata, 8'h41);
        check("lat_level1", Level, 4'd1);
        check("lat_fread_early", Fifo_Read, 1'b0);
        cyc(); #1;
        check("lat_fread", Fifo_Read, 1'b1);
        check("lat_fwrite_off", Fifo_Write, 1'b0);
        check("lat_level0", Level, 4'd0);
        check("lat_start_early", Tx_Start, 1'b0);
        cyc(); #1;
        check("lat_start", Tx_Start, 1'b1);
        check("lat_txdata", Tx_Data, 8'h41);
        check("lat_fread_off", Fifo_Read, 1'b0);
        cyc(); #1;
        check("lat_start_pulse", Tx_Start, 1'b0);
        check("lat_txdata_hold", Tx_Data, 8'h41);
        repeat (20) cyc();
        check("lat_read_count", rd_cnt - rbase, 1);

        // ---- fill to full with both sources contending ----
        do_reset();
        wbase = wr_cnt;
        exp_q.delete();
        for (int i = 0; i < 20; i++) begin
            Req0_Valid = 1'b1; Req0_Data = 8'h10 + 8'(i);
            Req1_Valid = 1'b1; Req1_Data = 8'h80 + 8'(i);
            #1;
            check($sformatf("rr%0d_ready0", i), Req0_Ready, (i < 15) && (i % 2 == 0));
            check($sformatf("rr%0d_ready1", i), Req1_Ready, (i < 15) && (i % 2 == 1));
            if (i < 15) exp_q.push_back((i % 2 == 0) ? 8'h10 + 8'(i) : 8'h80 + 8'(i));
            cyc();
        end
        Req0_Valid = 1'b0; Req1_Valid = 1'b0;
        #1;
        check("full_level", Level, 4'd15);
        check("full_write_count", wr_cnt - wbase, 15);

        // ---- drain everything in order ----
        rbase = rd_cnt;
        lbase = tx_log.size();
        Tx_Enable = 1'b1;
        repeat (400) cyc();
        #1;
        check("drain_level", Level, 4'd0);
        check("drain_read_count", rd_cnt - rbase, 15);
        check("drain_start_count", tx_log.size() - lbase, 15);
        for (int i = 0; i < 15; i++) begin
            if (lbase + i < tx_log.size())
                check($sformatf("drain_byte%0d", i), tx_log[lbase + i], exp_q[i]);
        end
        check("start_while_busy", busy_viol, 0);

        // ---- full boundary with a read decision in the same cycle ----
        do_reset();
        lbase = tx_log.size();
        fill0(15, 8'h20);
        #1 check("fb_level_full", Level, 4'd15);
        Tx_Enable = 1'b1;
        Req1_Valid = 1'b1; Req1_Data = 8'hC5;
        #1;
        check("fb_ready1_blocked", Req1_Ready, 1'b0);
        check("fb_ready0_blocked", Req0_Ready, 1'b0);
        cyc(); #1;
        check("fb_ready1_next", Req1_Ready, 1'b1);
        check("fb_level14", Level, 4'd14);
        cyc(); Req1_Valid = 1'b0;
        #1;
        check("fb_level15", Level, 4'd15);
        check("fb_fwrite", Fifo_Write, 1'b1);
        check("fb_wdata", Fifo_Wdata, 8'hC5);
        repeat (400) cyc();
        #1;
        check("fb_start_count", tx_log.size() - lbase, 16);
        if (tx_log.size() > 0) check("fb_last_byte", tx_log[tx_log.size() - 1], 8'hC5);
        check("fb_level_end", Level, 4'd0);

        // ---- accept and read together at Level 3 ----
        do_reset();
        fill0(3, 8'h30);
        #1 check("bal_level_pre", Level, 4'd3);
        Tx_Enable = 1'b1;
        Req0_Valid = 1'b1; Req0_Data = 8'h33;
        #1 check("bal_ready0", Req0_Ready, 1'b1);
        cyc(); Req0_Valid = 1'b0;
        #1;
        check("bal_level", Level, 4'd3);
        check("bal_fread", Fifo_Read, 1'b1);
        check("bal_fwrite", Fifo_Write, 1'b1);

        // ---- reset in DRAIN with Level 5 ----
        do_reset();
        fill0(6, 8'h40);
        Tx_Enable = 1'b1;
        cyc(); Tx_Enable = 1'b0;
        #1;
        check("mr_fread", Fifo_Read, 1'b1);
        check("mr_level5", Level, 4'd5);
        cyc(); #1 check("mr_start", Tx_Start, 1'b1);
        cyc(); cyc(); #1 check("mr_level_drain", Level, 4'd5);
        Reset = 1'b0;
        cyc(); Reset = 1'b1;
        #1;
        check("mr_fwrite", Fifo_Write, 1'b0);
        check("mr_wdata", Fifo_Wdata, 8'h00);
        check("mr_fread0", Fifo_Read, 1'b0);
        check("mr_txstart", Tx_Start, 1'b0);
        check("mr_txdata", Tx_Data, 8'h00);
        check("mr_level0", Level, 4'd0);
        Tx_Enable = 1'b1;
        Req0_Valid = 1'b1; Req0_Data = 8'h5A;
        #1 check("mr_ready0", Req0_Ready, 1'b1);
        cyc(); Req0_Valid = 1'b0;
        #1 check("mr_new_fwrite", Fifo_Write, 1'b1);
        cyc(); #1 check("mr_new_fread", Fifo_Read, 1'b1);
        cyc(); #1;
        check("mr_new_start", Tx_Start, 1'b1);
        check("mr_new_data", Tx_Data, 8'h5A);
        repeat (20) cyc();
        check("final_start_while_busy", busy_viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_uart_tx_fifo_sequencer

// File: doc/uart_tx_fifo_sequencer.md
Name: uart_tx_fifo_sequencer

Overview:
Controller around the 8-bit UART transmit FIFO. Merges two byte sources into the single FIFO write port using round-robin arbitration, and drains the FIFO into the UART transmitter through a start/busy handshake. Keeps its own occupancy count so accept and read decisions never rely on the FIFO's registered (lagging) status. Sits between the command/host byte producers and the UART TX shifter.

Parameters:
ADDR_WIDTH, 4, FIFO address width; must match the attached FIFO.
DEPTH, (1<<ADDR_WIDTH)-1, usable FIFO entries (15 by default).

Ports:
Clk  in  1  clock; all state updates on posedge.
Reset  in  1  synchronous, active-low.
Req0_Valid  in  1  source 0 offers a byte.
Req0_Data  in  8  source 0 byte.
Req0_Ready  out  1  source 0 byte accepted this cycle.
Req1_Valid  in  1  source 1 offers a byte.
Req1_Data  in  8  source 1 byte.
Req1_Ready  out  1  source 1 byte accepted this cycle.
Fifo_Write  out  1  registered FIFO write strobe.
Fifo_Wdata  out  8  registered FIFO write data.
Fifo_Read  out  1  registered FIFO read strobe.
Fifo_Rdata  in  8  FIFO read data.
Tx_Enable  in  1  0 pauses draining; writes are still accepted.
Tx_Start  out  1  one-cycle start pulse to the transmitter.
Tx_Data  out  8  byte for the transmitter; held until the next load.
Tx_Busy  in  1  transmitter is shifting.
Level  out  ADDR_WIDTH  internal occupancy count, 0..DEPTH.

Behaviour:
- Reset (Reset=0 at posedge): Fifo_Write=0, Fifo_Wdata=0, Fifo_Read=0, Tx_Start=0, Tx_Data=0, Level=0, FSM=IDLE, Last_Grant=1 (source 0 has priority first). The FIFO shares the same Reset, so count 0 stays consistent with it. A reset mid-frame abandons the frame; Tx_Busy is ignored until IDLE.
- Write arbitration (combinational Ready):
  - When Level==DEPTH, both Ready outputs are 0.
  - Otherwise, if exactly one Valid is high, that source gets Ready.
  - If both are high, Ready goes to the source that is not Last_Grant.
  - Accept = Valid & Ready. On accept: Last_Grant is set to the granted source; Fifo_Write=1 and Fifo_Wdata=the byte on the next cycle. Otherwise Fifo_Write=0 and Fifo_Wdata holds its value.
  - The FIFO captures the write on the negedge inside the Fifo_Write cycle, giving half a cycle of setup.
- Drain FSM:
  - IDLE: if Tx_Enable & Level!=0 & !Tx_Busy, go to READ and assert Fifo_Read for the next cycle.
  - READ: Fifo_Read=1 for exactly one cycle; the FIFO updates its read side on that negedge. Go to LOAD.
  - LOAD: capture Tx_Data<=Fifo_Rdata, Tx_Start=1 for one cycle, go to HOLD.
  - HOLD: one cycle, allows Tx_Busy to rise. Go to DRAIN.
  - DRAIN: wait until Tx_Busy==0, then go to IDLE.
- Tx_Enable is sampled only in IDLE. Dropping it mid-frame does not abort the frame.
- Level arithmetic:
  - +1 on accept, -1 on the IDLE->READ decision; both together leave Level unchanged.
  - Never exceeds DEPTH and never underflows.
  - A byte accepted at edge k can trigger a read at edge k+1 at the earliest, so the FIFO write always lands before the read.
- Latency: accept at edge k, then Fifo_Write during k..k+1, Fifo_Read during k+1..k+2, Tx_Start during k+2..k+3. Minimum of 3 cycles plus the frame time per byte.
- Full boundary: at Level==DEPTH with a read decision in the same cycle, no source is accepted that cycle. Acceptance resumes the next cycle.
- Pointer wrap-around is handled inside the FIFO; the controller uses only Level.

Decomposition:
- Shared package uart_fifo_pkg holds:
  - FIFO status bit positions: EMPTY=0, FULL=1, AFULL=2, AEMPTY=3.
  - Drain FSM state encodings: IDLE, READ, LOAD, HOLD, DRAIN.
  - Default ADDR_WIDTH.
- One sub-module, rr_arbiter2: inputs are two Valid lines, Last_Grant and a Block signal; outputs are the two Grant lines. It is purely combinational. The Last_Grant register stays in the parent.

Test Plan:
- Reset, then Req0_Valid=1 with Req0_Data=0x41 for one cycle, Tx_Busy model 10 cycles -> Fifo_Write with 0x41 the next cycle; Fifo_Read one cycle later; Tx_Start with Tx_Data=0x41 one cycle after that; Level goes 1 then 0.
- Req0 and Req1 both Valid continuously with distinct data, Tx_Enable=0 -> grants alternate 0,1,0,1; acceptance stops at Level=15 with both Ready=0; Fifo_Write count is 15.
- From the full state, raise Tx_Enable -> 15 bytes are transmitted in the accepted order, one Tx_Start per byte, never while Tx_Busy=1; Level ends at 0 and no extra Fifo_Read is issued.
- Level=15 and read decision in the same cycle with Req1_Valid=1 -> Req1 not accepted that cycle, accepted the next; Level stays ≤15.
- Simultaneous accept and read at Level=3 -> Level stays 3.
- Reset asserted during DRAIN with Level=5 -> next cycle all outputs are 0, FSM=IDLE, Level=0; a new byte afterwards is transmitted normally.
